// File: rtl/game_pkg.sv
// Shared definitions for the memory-match game controller: 3-bit state
// encodings and a small state-classification helper.
package game_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_GEN  = 3'd1;
    localparam state_t S_ADDR = 3'd2;
    localparam state_t S_CMP  = 3'd3;
    localparam state_t S_WIN  = 3'd4;
    localparam state_t S_DONE = 3'd5;
    localparam state_t S_FAIL = 3'd6;

    // States in which the player is being waited on (subject to the round timeout).
    function automatic logic is_wait_state(input state_t s);
        return (s == S_ADDR) || (s == S_CMP);
    endfunction

endpackage

// File: rtl/state_timer.sv
// Per-state cycle timer. Counts cycles while enabled, restarts on clear, and
// flags the TIMEOUT_CYC-th consecutive enabled cycle so the owner can leave
// the state at the end of that cycle. The count saturates instead of wrapping.
module state_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TMW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMW-1:0] CNT_MAX  = TMW'(TIMEOUT_CYC);
    localparam logic [TMW-1:0] CNT_LAST = TMW'(TIMEOUT_CYC - 1);

    logic [TMW-1:0] count;

    // Count completed cycles in the current state; clear restarts on a state change.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the cycles already spent, so count==TIMEOUT_CYC-1 is the last allowed cycle.
    assign expired = enable && (count >= CNT_LAST);

endmodule

// File: rtl/seq_game_ctrl.sv
// Multi-round controller for the memory-match game:
//   IDLE -> GEN -> ADDR -> CMP -> WIN/FAIL, repeated for ROUNDS rounds, with a
//   per-round retry limit and saturating round/score/tries counters.
// Optional feature macro: ROUND_TIMEOUT_EN adds a TIMEOUT_CYC-cycle limit on
// the ADDR and CMP states (expiry -> FAIL). Without it those states wait forever.
module seq_game_ctrl
    import game_pkg::*;
#(
    parameter int ROUNDS      = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           next,
    input  logic                           confirm,
    input  logic                           abort,
    input  logic                           cmp_valid,
    input  logic                           match,
    output state_t                         state,
    output logic [$clog2(ROUNDS+1)-1:0]    round,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [$clog2(ROUNDS+1)-1:0]    score,
    output logic                           gen_pulse,
    output logic                           done,
    output logic                           fail
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [RW-1:0] SCORE_MAX  = RW'(ROUNDS);
    localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);

    state_t          state_nxt;
    logic [RW-1:0]   round_nxt;
    logic [RW-1:0]   score_nxt;
    logic [TW-1:0]   tries_nxt;
    logic            timeout;

`ifdef ROUND_TIMEOUT_EN
    // Round timer restarts whenever the state is about to change.
    state_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_state_timer (
        .clk     (clk),
        .rst     (rst || abort),
        .clear   (state_nxt != state),
        .enable  (is_wait_state(state)),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;

    // Keeps the timeout parameter referenced in builds without the timer.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // Next-state and counter decode; abort overrides every transition.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        round_nxt = round;
        score_nxt = score;
        tries_nxt = tries_left;

        if (abort) begin
            state_nxt = S_IDLE;
            round_nxt = '0;
            score_nxt = '0;
            tries_nxt = TRIES_INIT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_GEN;
                        round_nxt = '0;
                        score_nxt = '0;
                        tries_nxt = TRIES_INIT;
                    end
                end
                S_GEN: begin
                    if (next) state_nxt = S_ADDR;
                end
                S_ADDR: begin
                    if (timeout)      state_nxt = S_FAIL;
                    else if (confirm) state_nxt = S_CMP;
                end
                S_CMP: begin
                    // A matcher result arriving on the expiry cycle beats the timeout.
                    if (cmp_valid) begin
                        if (match) begin
                            state_nxt = S_WIN;
                            if (score != SCORE_MAX) score_nxt = score + 1'b1;
                        end else if (tries_left <= TW'(1)) begin
                            state_nxt = S_FAIL;
                            tries_nxt = '0;
                        end else begin
                            state_nxt = S_ADDR;
                            tries_nxt = tries_left - 1'b1;
                        end
                    end else if (timeout) begin
                        state_nxt = S_FAIL;
                    end
                end
                S_WIN: begin
                    if (round == LAST_ROUND) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_GEN;
                        round_nxt = round + 1'b1;
                        tries_nxt = TRIES_INIT;
                    end
                end
                S_DONE, S_FAIL: begin
                    // Counters stay visible until the next game starts.
                    if (start) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State/counter registers; gen_pulse fires on the cycle GEN is entered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state      <= S_IDLE;
            round      <= '0;
            score      <= '0;
            tries_left <= TRIES_INIT;
            gen_pulse  <= 1'b0;
        end else begin
            state      <= state_nxt;
            round      <= round_nxt;
            score      <= score_nxt;
            tries_left <= tries_nxt;
            gen_pulse  <= (state_nxt == S_GEN) && (state != S_GEN);
        end
    end

    // Terminal-state flags follow the state register directly.
    assign done = (state == S_DONE);
    assign fail = (state == S_FAIL);

endmodule
